spi_flash_word_reader: RTL and testbench
========================================

Name: spi_flash_word_reader

Overview:
- SPI-mode-0 initiator that fetches 32-bit words from the external serial flash using the single-bit READ command (0x03) and a 24-bit address.
- Drives the same cs/sclk/si/so/wp/hold pins that the flash buffer mock responds to, and serves the instruction-fetch and data-load paths of basic_soc.
- Keeps CS asserted after a word so that a sequential next fetch continues the burst without re-sending command and address.

Parameters:
- SCLK_HALF, 1, clk cycles per SCLK half-period (≥1)
- CS_HIGH_CYCLES, 2, minimum cycles CS stays deasserted between transactions (≥1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  word read request
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  24  flash byte address (any alignment)
- resp_valid  output  1  one-cycle pulse, resp_data valid
- resp_data  output  32  word read; first flash byte in [7:0]
- cs  output  1  flash chip select, active low
- sclk  output  1  SPI clock, idles low
- si  output  1  MOSI
- so  input  1  MISO
- wp  output  1  constant 1
- hold  output  1  constant 1

Behaviour:
- Reset values (also apply on rst mid-transfer, same cycle): cs=1, sclk=0, si=0, req_ready=0, resp_valid=0, resp_data=0, state=IDLE, burst-valid flag cleared. No partial response after reset.
- States: IDLE, CS_GAP, CMD, ADDR, DATA, HOLD.
- req_ready=1 only in IDLE and HOLD; 0 in every other state and during rst.
- Bit timing (CMD/ADDR/DATA):
  - Each bit is SCLK_HALF cycles with sclk=0, then SCLK_HALF cycles with sclk=1.
  - si updates at the start of the low phase, MSB first.
  - so is captured on the clk edge that ends the high phase.
- IDLE + accept: cs goes low next cycle, then CMD.
  - CMD: 8 bits, 0x03.
  - ADDR: 24 bits of req_addr, MSB first.
  - DATA: 32 bits, each byte assembled MSB-first. Byte k is placed in resp_data[8k+7:8k].
- After the last DATA bit:
  - resp_valid pulses for 1 cycle and resp_data updates.
  - next_addr = (addr+4) mod 2^24.
  - State goes to HOLD with cs=0 and sclk=0.
- Fresh-read latency: acceptance at cycle 0 gives resp_valid at cycle 1+128*SCLK_HALF (129 for the default).
- HOLD + accept with req_addr==next_addr: straight to DATA, no command or address. resp_valid at cycle 1+64*SCLK_HALF (65 for the default).
- HOLD + accept with any other address: cs=1 for exactly CS_HIGH_CYCLES (CS_GAP), then a fresh CMD/ADDR/DATA sequence. Latency is CS_HIGH_CYCLES+1+128*SCLK_HALF.
- HOLD with no request: cs stays low indefinitely and sclk does not toggle.
- Wrap-around: next_addr after 0xFFFFFC is 0x000000, and continuation applies, matching the flash's natural wrap.
- req_addr is latched at acceptance; later changes are ignored.
- No response backpressure: the consumer must take resp_data in the resp_valid cycle.
- resp_data holds its value until the next response.

Test Plan:
- Flash mock with bytes 00..3F = 0x00,0x01,…,0x3F; SCLK_HALF=1. Read addr 0x000004 → resp_data=0x07060504 exactly 129 cycles after accept. Check cs low and exactly 64 sclk rising edges; si stream = 0x03, 0x000004.
- Immediately read 0x000008 → no cs rise, 32 sclk edges, resp_data=0x0B0A0908 at +65 cycles.
- From HOLD, read 0x000020 → cs high for exactly 2 cycles, then a full command. resp_data=0x23222120 at +131 cycles.
- Unaligned read 0x000001 → 0x04030201.
- Assert rst midway through ADDR → same-cycle cs=1, sclk=0, req_ready=0, and no resp_valid. After release, read 0x000000 → 0x03020100 via the full sequence.
- SCLK_HALF=3 and a request at 0xFFFFFC with mock wrap → 385-cycle latency, correct word. Next request 0x000000 continues without a new command.

Source files
------------

// File: rtl/spi_flash_word_reader.sv
// SPI mode-0 READ (0x03) initiator returning 32-bit little-endian words from serial flash.
// CS stays low after a word so that a sequential fetch continues the burst without command/address.
module spi_flash_word_reader #(
    parameter int SCLK_HALF      = 1,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        cs,
    output logic        sclk,
    output logic        si,
    input  logic        so,
    output logic        wp,
    output logic        hold
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int GW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH_CYCLES - 1);
    localparam logic [7:0]    CMD_READ  = 8'h03;

    typedef enum logic [2:0] {IDLE, CS_GAP, CMD, ADDR, DATA, HOLD} state_e;

    state_e      state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [4:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic        si_q, si_d;
    logic        cs_q, cs_d;
    logic        resp_valid_q, resp_valid_d;
    logic        burst_q, burst_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [23:0] addr_q, addr_d;

    logic        accept;
    logic        shifting;
    logic        phase_end;
    logic        bit_end;
    logic [31:0] rx_full;

    assign req_ready = ((state_q == IDLE) || (state_q == HOLD)) && !rst;
    assign accept    = req_valid && req_ready;
    assign shifting  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign phase_end = shifting && (half_q == HALF_LAST);
    assign bit_end   = phase_end && sclk_q;
    assign rx_full   = {rx_q[30:0], so};

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        gap_d        = gap_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        si_d         = si_q;
        cs_d         = cs_q;
        resp_valid_d = 1'b0;
        burst_d      = burst_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        resp_data_d  = resp_data_q;
        addr_d       = addr_q;

        if (phase_end) begin
            half_d = '0;
            sclk_d = ~sclk_q;
        end else if (shifting) begin
            half_d = half_q + HW'(1);
        end

        // End of a high phase: advance MOSI to the next bit and capture MISO.
        if (bit_end) begin
            bit_d = bit_q + 5'd1;
            tx_d  = {tx_q[30:0], 1'b0};
            si_d  = tx_q[30];
            if (state_q == DATA) rx_d = rx_full;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CMD;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    half_d  = '0;
                    bit_d   = '0;
                    tx_d    = {CMD_READ, req_addr};
                    si_d    = CMD_READ[7];
                    addr_d  = req_addr;
                    burst_d = 1'b0;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (burst_q && (req_addr == addr_q)) begin
                        state_d = DATA;
                        sclk_d  = 1'b0;
                        half_d  = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = CS_GAP;
                        cs_d    = 1'b1;
                        gap_d   = '0;
                        tx_d    = {CMD_READ, req_addr};
                        si_d    = 1'b0;
                        addr_d  = req_addr;
                        burst_d = 1'b0;
                    end
                end
            end
            CS_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = CMD;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    half_d  = '0;
                    bit_d   = '0;
                    si_d    = tx_q[31];
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            CMD: begin
                if (bit_end && (bit_q == 5'd7)) begin
                    state_d = ADDR;
                    bit_d   = '0;
                end
            end
            ADDR: begin
                if (bit_end && (bit_q == 5'd23)) begin
                    state_d = DATA;
                    bit_d   = '0;
                    si_d    = 1'b0;
                end
            end
            DATA: begin
                // First byte on the wire lands in the least significant byte.
                if (bit_end && (bit_q == 5'd31)) begin
                    state_d      = HOLD;
                    resp_valid_d = 1'b1;
                    resp_data_d  = {rx_full[7:0], rx_full[15:8], rx_full[23:16], rx_full[31:24]};
                    addr_d       = addr_q + 24'd4;
                    burst_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            half_q       <= '0;
            gap_q        <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b0;
            si_q         <= 1'b0;
            cs_q         <= 1'b1;
            resp_valid_q <= 1'b0;
            burst_q      <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            gap_q        <= gap_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            si_q         <= si_d;
            cs_q         <= cs_d;
            resp_valid_q <= resp_valid_d;
            burst_q      <= burst_d;
            resp_data_q  <= resp_data_d;
        end
        tx_q   <= tx_d;
        rx_q   <= rx_d;
        addr_q <= addr_d;
    end

    // Reset forces the pins idle in the same cycle it is asserted.
    assign cs         = cs_q | rst;
    assign sclk       = sclk_q & ~rst;
    assign si         = si_q & ~rst;
    assign resp_valid = resp_valid_q & ~rst;
    assign resp_data  = rst ? 32'h0 : resp_data_q;
    assign wp         = 1'b1;
    assign hold       = 1'b1;

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Bench for spi_flash_word_reader: flash mock (byte at address A = A[7:0]) plus a response scoreboard.
module tb_spi_flash_word_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_i       [2];
    logic        req_valid_i [2];
    logic [23:0] req_addr_i  [2];
    logic        so_i        [2];
    logic        req_ready_o [2];
    logic        resp_valid_o[2];
    logic [31:0] resp_data_o [2];
    logic        cs_o        [2];
    logic        sclk_o      [2];
    logic        si_o        [2];
    logic        wp_o        [2];
    logic        hold_o      [2];

    spi_flash_word_reader #(.SCLK_HALF(1), .CS_HIGH_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst_i[0]), .req_valid(req_valid_i[0]), .req_ready(req_ready_o[0]),
        .req_addr(req_addr_i[0]), .resp_valid(resp_valid_o[0]), .resp_data(resp_data_o[0]),
        .cs(cs_o[0]), .sclk(sclk_o[0]), .si(si_o[0]), .so(so_i[0]), .wp(wp_o[0]), .hold(hold_o[0])
    );

    spi_flash_word_reader #(.SCLK_HALF(3), .CS_HIGH_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst_i[1]), .req_valid(req_valid_i[1]), .req_ready(req_ready_o[1]),
        .req_addr(req_addr_i[1]), .resp_valid(resp_valid_o[1]), .resp_data(resp_data_o[1]),
        .cs(cs_o[1]), .sclk(sclk_o[1]), .si(si_o[1]), .so(so_i[1]), .wp(wp_o[1]), .hold(hold_o[1])
    );

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int resp_cnt = 0;
    int acc_cyc[2];

    // Mock flash state
    logic        sclk_prev[2];
    logic        cs_prev  [2];
    int          mcnt     [2];
    logic [31:0] mshift   [2];
    logic [23:0] mptr     [2];
    int          mbit     [2];
    logic [7:0]  cmd_seen [2];
    logic [23:0] addr_seen[2];
    int          sclk_rise[2];
    int          cs_rise  [2];
    int          cs_hi    [2];

    int rise0, csr0, cshi0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Flash mock and response monitor, both sampled on the falling clk edge.
    initial begin
        exp_t        e;
        logic [7:0]  b;
        for (int g = 0; g < 2; g++) begin
            sclk_prev[g] = 1'b0;
            cs_prev[g]   = 1'b1;
            so_i[g]      = 1'b0;
            mcnt[g]      = 0;
            mbit[g]      = 7;
            mptr[g]      = '0;
            mshift[g]    = '0;
            cmd_seen[g]  = '0;
            addr_seen[g] = '0;
            sclk_rise[g] = 0;
            cs_rise[g]   = 0;
            cs_hi[g]     = 0;
            acc_cyc[g]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (cs_o[g] && !cs_prev[g]) cs_rise[g]++;
                if (cs_o[g]) begin
                    cs_hi[g]++;
                    mcnt[g] = 0;
                end else if (sclk_o[g] && !sclk_prev[g]) begin
                    sclk_rise[g]++;
                    if (mcnt[g] < 32) begin
                        mshift[g] = {mshift[g][30:0], si_o[g]};
                        mcnt[g]++;
                        if (mcnt[g] == 32) begin
                            cmd_seen[g]  = mshift[g][31:24];
                            addr_seen[g] = mshift[g][23:0];
                            mptr[g]      = mshift[g][23:0];
                            mbit[g]      = 7;
                        end
                    end
                end else if (!sclk_o[g] && sclk_prev[g] && mcnt[g] == 32) begin
                    b = mptr[g][7:0];
                    so_i[g] = b[mbit[g]];
                    if (mbit[g] == 0) begin
                        mbit[g] = 7;
                        mptr[g] = mptr[g] + 24'd1;
                    end else begin
                        mbit[g] = mbit[g] - 1;
                    end
                end
                sclk_prev[g] = sclk_o[g];
                cs_prev[g]   = cs_o[g];

                if (req_valid_i[g] && req_ready_o[g]) acc_cyc[g] = cyc;
                if (resp_valid_o[g]) begin
                    resp_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'(g), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_inst", 32'(g), 32'(e.inst));
                        check("resp_data", resp_data_o[g], e.data);
                        check("resp_latency", 32'(cyc - acc_cyc[g]), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic snap(input int g);
        rise0 = sclk_rise[g];
        csr0  = cs_rise[g];
        cshi0 = cs_hi[g];
    endtask

    task automatic read(input int g, input logic [23:0] a, input logic [31:0] d, input int lat);
        int n;
        int start;
        n = 0;
        while (!req_ready_o[g] && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready_o[g]) begin
            check("ready_timeout", 32'(req_ready_o[g]), 32'd1);
            return;
        end
        exp_q.push_back('{inst: g, data: d, lat: lat});
        start = resp_cnt;
        snap(g);
        req_valid_i[g] = 1'b1;
        req_addr_i[g]  = a;
        @(posedge clk); #1;
        req_valid_i[g] = 1'b0;
        req_addr_i[g]  = ~a;
        n = 0;
        while (resp_cnt == start && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (resp_cnt == start) check("resp_timeout", 32'(resp_cnt), 32'(start + 1));
        #1;
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_i[g]       = 1'b1;
            req_valid_i[g] = 1'b0;
            req_addr_i[g]  = '0;
        end
        repeat (4) @(posedge clk);
        #1;
        check("rst_cs", 32'(cs_o[0]), 32'd1);
        check("rst_sclk", 32'(sclk_o[0]), 32'd0);
        check("rst_si", 32'(si_o[0]), 32'd0);
        check("rst_ready", 32'(req_ready_o[0]), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o[0]), 32'd0);
        check("rst_resp_data", resp_data_o[0], 32'd0);
        check("wp_hold", {30'd0, wp_o[0], hold_o[0]}, 32'd3);
        rst_i[0] = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(req_ready_o[0]), 32'd1);
        check("idle_cs", 32'(cs_o[0]), 32'd1);

        // Fresh read from IDLE
        read(0, 24'h000004, 32'h07060504, 129);
        check("r1_sclk_rises", 32'(sclk_rise[0] - rise0), 32'd64);
        check("r1_cs_rises", 32'(cs_rise[0] - csr0), 32'd0);
        check("r1_cmd", 32'(cmd_seen[0]), 32'h03);
        check("r1_addr", 32'(addr_seen[0]), 32'h000004);
        check("r1_hold_cs", 32'(cs_o[0]), 32'd0);

        // Sequential continuation
        read(0, 24'h000008, 32'h0B0A0908, 65);
        check("r2_sclk_rises", 32'(sclk_rise[0] - rise0), 32'd32);
        check("r2_cs_rises", 32'(cs_rise[0] - csr0), 32'd0);

        // Non-sequential from HOLD: CS gap then full command
        read(0, 24'h000020, 32'h23222120, 131);
        check("r3_cs_rises", 32'(cs_rise[0] - csr0), 32'd1);
        check("r3_cs_high_cycles", 32'(cs_hi[0] - cshi0), 32'd2);
        check("r3_sclk_rises", 32'(sclk_rise[0] - rise0), 32'd64);
        check("r3_addr", 32'(addr_seen[0]), 32'h000020);

        // Unaligned
        read(0, 24'h000001, 32'h04030201, 131);
        check("r4_addr", 32'(addr_seen[0]), 32'h000001);

        // HOLD with no request: no clocking, CS stays low
        snap(0);
        repeat (10) @(posedge clk);
        #1;
        check("hold_idle_sclk", 32'(sclk_rise[0] - rise0), 32'd0);
        check("hold_idle_cs", 32'(cs_o[0]), 32'd0);
        check("hold_resp_data", resp_data_o[0], 32'h04030201);

        read(0, 24'h000005, 32'h08070605, 65);
        check("r5_sclk_rises", 32'(sclk_rise[0] - rise0), 32'd32);

        // Reset in the middle of ADDR
        req_valid_i[0] = 1'b1;
        req_addr_i[0]  = 24'h000010;
        @(posedge clk); #1;
        req_valid_i[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("pre_rst_cs", 32'(cs_o[0]), 32'd0);
        rst_i[0] = 1'b1;
        #1;
        check("mid_rst_cs", 32'(cs_o[0]), 32'd1);
        check("mid_rst_sclk", 32'(sclk_o[0]), 32'd0);
        check("mid_rst_ready", 32'(req_ready_o[0]), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid_o[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i[0] = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("post_rst_resp_data", resp_data_o[0], 32'd0);
        check("post_rst_cs", 32'(cs_o[0]), 32'd1);

        read(0, 24'h000000, 32'h03020100, 129);
        check("r6_cmd", 32'(cmd_seen[0]), 32'h03);
        check("r6_addr", 32'(addr_seen[0]), 32'h000000);
        check("r6_sclk_rises", 32'(sclk_rise[0] - rise0), 32'd64);

        // Slower SCLK with address wrap
        rst_i[1] = 1'b0;
        @(posedge clk); #1;
        read(1, 24'hFFFFFC, 32'hFFFEFDFC, 385);
        check("w1_addr", 32'(addr_seen[1]), 32'hFFFFFC);
        check("w1_sclk_rises", 32'(sclk_rise[1] - rise0), 32'd64);
        read(1, 24'h000000, 32'h03020100, 193);
        check("w2_cs_rises", 32'(cs_rise[1] - csr0), 32'd0);
        check("w2_sclk_rises", 32'(sclk_rise[1] - rise0), 32'd32);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
